// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   sub_state_t        - controller state encoding (IDLE, RUN, DONE)
//   SUB_WIDTH_DEFAULT  - default operand/result width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin.
//
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in from the less significant bit
//   diff - difference bit
//   bout - borrow out to the more significant bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;

  // Borrow out when b exceeds a, or when the bits are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, processed LSB first, one bit
// per clock, through a single full_subtractor cell with the borrow kept in a flop.
//
// Parameters:
//   WIDTH  - operand/result width, 2..64
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active high
//   start  - request, sampled only in IDLE or DONE
//   a, b   - operands, captured on the accepting edge
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when diff/bout have just been updated
//   diff   - registered result a - b mod 2^WIDTH
//   bout   - registered final borrow (1 iff a < b unsigned)
//   ovf    - (only with SERIAL_SUBTRACTOR_OVF_EN) signed overflow of the result
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] acc_shifted;
  logic             accept;
  logic             last_bit;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // The new bit enters at the MSB; on the final step this is the full result,
  // so the commit takes it directly and partial results never reach diff.
  assign acc_shifted = {cell_diff, acc_q};
  assign accept      = start && (state_q == IDLE || state_q == DONE);
  assign last_bit    = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d    = acc_shifted[WIDTH-1:1];
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = acc_shifted;
          bout_d  = cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // Overflow only possible when operand signs differ; cell_diff is the result MSB.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8: reset state, a table of
// directed subtractions with latency/hold checks, back-to-back operation with
// mid-run operand changes, and a reset abort in the middle of a run.
// Connects and checks ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_diff;
  vec_t vecs [8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  // Free-running clock; the bench drives and samples on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present operands with start for one cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, W'(busy), W'(0));
    checkOutput({tag, "_done"}, W'(done), W'(0));
  endtask

  // Full operation: busy for W cycles with diff holding the old result, then a
  // single done cycle with the new result, then back to idle.
  task automatic runOp(input vec_t v, input string tag);
    applyStimulus(v.a, v.b);
    for (int i = 0; i < W; i++) begin
      checkOutput({tag, "_busy"}, W'(busy), W'(1));
      checkOutput({tag, "_done_low"}, W'(done), W'(0));
      checkOutput({tag, "_diff_hold"}, diff, prev_diff);
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, W'(done), W'(1));
    checkOutput({tag, "_busy_low"}, W'(busy), W'(0));
    checkOutput({tag, "_diff"}, diff, v.diff);
    checkOutput({tag, "_bout"}, W'(bout), W'(v.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checkOutput({tag, "_ovf"}, W'(ovf), W'(v.ovf));
`endif
    prev_diff = v.diff;
    @(negedge clk);
    checkIdle({tag, "_after"});
    checkOutput({tag, "_diff_kept"}, diff, v.diff);
  endtask

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'hFF, b: 8'h01, diff: 8'hFE, bout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, bout: 1'b1, ovf: 1'b0};

    // Reset with start held high: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    @(negedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_diff", diff, 8'h00);
    checkOutput("reset_bout", W'(bout), W'(0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checkOutput("reset_ovf", W'(ovf), W'(0));
`endif
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");
    prev_diff = 8'h00;

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high throughout; operands changed mid-run.
    a     = 8'h05;
    b     = 8'h03;
    start = 1'b1;
    @(negedge clk);
    a = 8'h09;
    b = 8'h04;
    for (int i = 0; i < W; i++) begin
      checkOutput("b2b1_busy", W'(busy), W'(1));
      @(negedge clk);
    end
    checkOutput("b2b1_done", W'(done), W'(1));
    checkOutput("b2b1_diff", diff, 8'h02);
    checkOutput("b2b1_bout", W'(bout), W'(0));
    @(negedge clk);
    checkOutput("b2b2_no_bubble", W'(busy), W'(1));
    a = 8'h33;
    b = 8'h11;
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      checkOutput("b2b2_busy", W'(busy), W'(1));
    end
    @(negedge clk);
    checkOutput("b2b2_done", W'(done), W'(1));
    checkOutput("b2b2_diff", diff, 8'h05);
    checkOutput("b2b2_bout", W'(bout), W'(0));
    start = 1'b0;
    @(negedge clk);
    checkIdle("b2b_end");
    checkOutput("b2b_end_diff", diff, 8'h05);

    // Reset abort after four bits of 0x80 - 0x01.
    applyStimulus(8'h80, 8'h01);
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle("abort");
    checkOutput("abort_diff", diff, 8'h00);
    checkOutput("abort_bout", W'(bout), W'(0));
    prev_diff = 8'h00;
    runOp(vecs[4], "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. It drives a single instance of the existing full_subtractor cell, with the borrow held in a flop between bits. It trades area for latency and serves as the sequential front end around the combinational subtractor cell, for datapaths such as serial ALUs and restoring dividers.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk    input   1      system clock, rising-edge
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only when not busy
a      input   WIDTH  minuend, captured on the accepting edge
b      input   WIDTH  subtrahend, captured on the accepting edge
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse: diff/bout updated
diff   output  WIDTH  registered result a - b mod 2^WIDTH
bout   output  1      registered final borrow (1 iff a < b unsigned)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. Both are fixed.
- Reset (rst high at an edge): state IDLE, busy=0, done=0, diff=0, bout=0, borrow=0, bit counter=0, operand shift regs=0. rst overrides start.
- States and transitions:
  - IDLE: start=1 → capture a,b into shift regs, borrow<=0, cnt<=0, go RUN.
  - RUN: each edge performs one bit step (below). At the edge where cnt==WIDTH-1, go DONE.
  - DONE: done=1 for exactly this cycle. start=1 → capture and go RUN (back-to-back, no idle bubble). Otherwise go IDLE.
- Bit step (RUN only):
  - full_subtractor inputs: a_sh[0], b_sh[0], borrow. Its diff bit shifts into the MSB of the internal acc reg.
  - borrow <= cell bout; a_sh, b_sh shift right by 1; cnt++.
- Commit: on the final RUN edge, diff <= completed acc and bout <= cell bout, atomically. Between commits diff/bout hold the previous result; partial results are never visible.
- busy: 1 exactly in RUN. done: 1 exactly in DONE. busy and done are never both 1.
- Latency:
  - Start accepted at edge E0.
  - busy is high for WIDTH cycles.
  - done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the start-high cycle.
  - Throughput: one result per WIDTH+1 cycles.
- Boundary conditions:
  - start in RUN is ignored; no queuing.
  - a/b changes after the accepting edge have no effect.
  - rst in RUN aborts the operation; the next cycle shows busy=0, done=0, diff=0.
  - a==b gives diff=0, bout=0.
  - a=0, b=2^WIDTH-1 gives diff=1, bout=1 (wrap-around).
- cnt width: $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the operand MSBs captured at acceptance.
  - Committed on the same edge as diff; reset value 0; holds between commits.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum typedef sub_state_t {IDLE, RUN, DONE} (2 bits)
  - localparam SUB_WIDTH_DEFAULT = 8
- Sub-module: instantiate the existing full_subtractor for the per-bit cell. Do not re-implement it inline.
- FSM, counter and shift registers stay in serial_subtractor; no further split.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle → busy high 8 cycles, done pulse on cycle 9 after start, diff=0x02, bout=0.
- a=0x03, b=0x05 → diff=0xFE, bout=1. a=0x00, b=0xFF → diff=0x01, bout=1. a=b=0xA5 → diff=0x00, bout=0.
- Back-to-back: start held high continuously with a/b changed every result → new RUN begins the cycle after each done. A start held during RUN is ignored, and changing a/b mid-RUN leaves the result unchanged.
- rst asserted at RUN bit 4 of 0x80-0x01 → next cycle busy=0, done=0, diff=0, bout=0. A fresh start then completes normally with diff=0x7F.
- SERIAL_SUBTRACTOR_OVF_EN: 0x80-0x01 → diff=0x7F, ovf=1; 0x7F-0xFF → diff=0x80, ovf=1; 0x05-0x03 → ovf=0.
- Reset check: all outputs 0 after rst, with start=1 held during rst.
